// File: rtl/alu_16bit_reg.sv
// Registered MIPS-style ALU built from a ripple chain of 1-bit slices (AND/OR/ADD/SLT).
// Define ALU_OVERFLOW_EN to add a registered signed-overflow output.
module alu_16bit_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             ainvert,
  input  logic             bnegate,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
`ifdef ALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             cout,
  output logic             zero
);

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] or_bits;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH:0]   carry;
  logic             ovf;
  logic             slt_bit;

  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic             cout_reg;
  logic             cout_next;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slice
      // One ALU slice: operand inversion, logic ops and a full adder.
      assign a_eff[gi]     = a[gi] ^ ainvert;
      assign b_eff[gi]     = b[gi] ^ bnegate;
      assign and_bits[gi]  = a_eff[gi] & b_eff[gi];
      assign or_bits[gi]   = a_eff[gi] | b_eff[gi];
      assign sum_bits[gi]  = a_eff[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi + 1] = (a_eff[gi] & b_eff[gi]) | (carry[gi] & (a_eff[gi] ^ b_eff[gi]));
    end
  endgenerate

  // Signed overflow corrects the sign bit so SLT is right even when the subtraction overflows.
  assign ovf     = carry[WIDTH] ^ carry[WIDTH-1];
  assign slt_bit = sum_bits[WIDTH-1] ^ ovf;

  always_comb begin
    result_next = '0;
    cout_next   = 1'b0;
    case (op)
      2'b00: result_next = and_bits;
      2'b01: result_next = or_bits;
      2'b10: begin
        result_next = sum_bits;
        cout_next   = carry[WIDTH];
      end
      default: begin
        result_next = {{(WIDTH-1){1'b0}}, slt_bit};
        cout_next   = carry[WIDTH];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_reg <= '0;
      cout_reg   <= 1'b0;
    end else begin
      result_reg <= result_next;
      cout_reg   <= cout_next;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic overflow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= op[1] ? ovf : 1'b0;
    end
  end

  assign overflow = overflow_reg;
`endif

  assign result = result_reg;
  assign cout   = cout_reg;
  assign zero   = ~|result_reg;

endmodule

// File: tb/tb_alu_16bit_reg.sv
// Scoreboard bench for alu_16bit_reg: stimulus pushes expected values, a monitor pops after each clock.
module tb_alu_16bit_reg;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        ainvert;
  logic        bnegate;
  logic [1:0]  op;
  logic [15:0] result;
  logic        cout;
  logic        zero;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_16bit_reg #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .ainvert  (ainvert),
    .bnegate  (bnegate),
    .op       (op),
    .result   (result),
`ifdef ALU_OVERFLOW_EN
    .overflow (overflow),
`endif
    .cout     (cout),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on the effective operands.
  function automatic exp_t model(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                                 input logic ainv, input logic bneg, input logic [1:0] o,
                                 input string tag);
    exp_t e;
    logic [15:0] ae;
    logic [15:0] be;
    int unsigned usum;
    int ssum;
    ae = ainv ? ~ai : ai;
    be = bneg ? ~bi : bi;
    usum = int'(ae) + int'(be) + int'(ci);
    ssum = int'($signed(ae)) + int'($signed(be)) + int'(ci);
    e.tag = tag;
    e.c   = 1'b0;
    e.v   = 1'b0;
    case (o)
      2'b00: e.res = ae & be;
      2'b01: e.res = ae | be;
      2'b10: e.res = usum[15:0];
      default: e.res = (ssum < 0) ? 16'd1 : 16'd0;
    endcase
    if (o[1]) begin
      e.c = (usum >= 32'd65536);
      e.v = (ssum > 32767) || (ssum < -32768);
    end
    return e;
  endfunction

  task automatic issue(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                       input logic ainv, input logic bneg, input logic [1:0] o, input string tag);
    @(negedge clk);
    a = ai; b = bi; cin = ci; ainvert = ainv; bnegate = bneg; op = o;
    exp_q.push_back(model(ai, bi, ci, ainv, bneg, o, tag));
  endtask

  // Monitor: every registered output is compared one clock after its inputs were issued.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, "_result"}, result, e.res);
      check({e.tag, "_cout"}, {15'd0, cout}, {15'd0, e.c});
      check({e.tag, "_zero"}, {15'd0, zero}, {15'd0, (e.res == 16'd0)});
`ifdef ALU_OVERFLOW_EN
      check({e.tag, "_overflow"}, {15'd0, overflow}, {15'd0, e.v});
`endif
      $display("txn %s: result=%h cout=%b zero=%b", e.tag, result, cout, zero);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst = 1'b1; a = '0; b = '0; cin = 1'b0; ainvert = 1'b0; bnegate = 1'b0; op = 2'b00;
    #1;
    check("reset_result", result, 16'd0);
    check("reset_cout", {15'd0, cout}, 16'd0);
    check("reset_zero", {15'd0, zero}, 16'd1);
    @(negedge clk);
    rst = 1'b0;

    issue(16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 2'b00, "and_1_1");
    issue(16'd1, 16'd0, 1'b0, 1'b0, 1'b0, 2'b00, "and_1_0");
    issue(16'd1, 16'd0, 1'b0, 1'b0, 1'b0, 2'b01, "or_1_0");
    issue(16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 2'b00, "nor_0_0");
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 2'b01, "nand_ff_ff");
    issue(16'd1001, 16'd1234, 1'b0, 1'b0, 1'b0, 2'b10, "add_1001_1234");
    issue(16'hFFFF, 16'd1, 1'b0, 1'b0, 1'b0, 2'b10, "add_wrap");
    issue(16'h7FFF, 16'd1, 1'b0, 1'b0, 1'b0, 2'b10, "add_sovf");
    issue(16'd1001, 16'd1234, 1'b1, 1'b0, 1'b1, 2'b10, "sub_1001_1234");
    issue(16'd1234, 16'd1001, 1'b1, 1'b0, 1'b1, 2'b10, "sub_1234_1001");
    issue(16'd5, 16'd5, 1'b1, 1'b0, 1'b1, 2'b10, "sub_5_5");
    issue(16'hFFFD, 16'd2, 1'b1, 1'b0, 1'b1, 2'b11, "slt_m3_2");
    issue(16'd2, 16'hFFFD, 1'b1, 1'b0, 1'b1, 2'b11, "slt_2_m3");
    issue(16'h8000, 16'd1, 1'b1, 1'b0, 1'b1, 2'b11, "slt_min_1");
    issue(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 2'b11, "slt_max_m1");

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'h8000;
        1: ra = 16'h7FFF;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
      issue(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            $sformatf("rand%0d", i));
    end

    // Drain the scoreboard before the asynchronous reset sequence.
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) check("drain", 16'(exp_q.size()), 16'd0);

    issue(16'd1, 16'd2, 1'b0, 1'b0, 1'b0, 2'b10, "pre_reset_add");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_result", result, 16'd0);
    check("async_rst_cout", {15'd0, cout}, 16'd0);
    check("async_rst_zero", {15'd0, zero}, 16'd1);
    @(posedge clk);
    #1;
    check("rst_held_result", result, 16'd0);
    #1;
    rst = 1'b0;
    #1;
    check("rst_release_result", result, 16'd0);
    check("rst_release_zero", {15'd0, zero}, 16'd1);
    @(posedge clk);
    #1;
    check("post_rst_result", result, 16'd3);
    check("post_rst_zero", {15'd0, zero}, 16'd0);
    $display("txn post_reset: result=%h cout=%b zero=%b", result, cout, zero);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
